pipe_ctrl: RTL

- Centralised stall/bubble/flush controller for the parametrised THCO-MIPS pipeline; replaces the free-running pipeline registers with explicitly gated ones.
- Combines three stall sources into one per-stage hold vector and one per-stage bubble vector:
  - per-stage external stall requests;
  - internal load-use hazard detection;
  - a wait-state FSM for the shared instruction/data SRAM.
- Sits beside pc_reg and the stage registers; every pipeline register consumes one stall bit and one bubble bit.

---
 rtl/pipe_ctrl_pkg.sv | 24 ++
 rtl/pipe_ctrl_if.sv | 38 +++
 rtl/pipe_ctrl_stall_merge.sv | 23 ++
 rtl/pipe_ctrl.sv | 124 ++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the pipeline stall/bubble/flush controller.
package pipe_ctrl_pkg;

  localparam int unsigned STAGE_PC    = 0;
  localparam int unsigned STAGE_IFID  = 1;
  localparam int unsigned STAGE_IDEX  = 2;
  localparam int unsigned STAGE_EXMEM = 3;
  localparam int unsigned STAGE_MEMWB = 4;

  localparam int unsigned DEF_N_STAGES   = 5;
  localparam int unsigned DEF_REG_ADDR_W = 4;
  localparam int unsigned DEF_MEM_WAIT   = 2;

  // Wait counter covers MEM_WAIT values 0..15.
  localparam int unsigned MEM_CNT_W = 4;

  typedef enum logic [1:0] {
    MS_IDLE  = 2'd0,
    MS_WAIT  = 2'd1,
    MS_DONE  = 2'd2,
    MS_FETCH = 2'd3
  } mem_state_e;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Request/response bundle between the pipeline (master) and the stall controller (slave).
interface pipe_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned N_STAGES   = DEF_N_STAGES,
  parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W
);

  logic [N_STAGES-1:0]   stallreq_i;
  logic                  flush_i;
  logic                  id_rEnable1_i;
  logic [REG_ADDR_W-1:0] id_rAddr1_i;
  logic                  id_rEnable2_i;
  logic [REG_ADDR_W-1:0] id_rAddr2_i;
  logic                  ex_memRead_i;
  logic                  ex_wReg_i;
  logic [REG_ADDR_W-1:0] ex_wRegAddr_i;
  logic                  mem_req_i;
  logic [N_STAGES-1:0]   stall_o;
  logic [N_STAGES-1:0]   bubble_o;
  logic                  mem_done_o;
  logic                  busy_o;

  modport master (
    output stallreq_i, flush_i,
    output id_rEnable1_i, id_rAddr1_i, id_rEnable2_i, id_rAddr2_i,
    output ex_memRead_i, ex_wReg_i, ex_wRegAddr_i, mem_req_i,
    input  stall_o, bubble_o, mem_done_o, busy_o
  );

  modport slave (
    input  stallreq_i, flush_i,
    input  id_rEnable1_i, id_rAddr1_i, id_rEnable2_i, id_rAddr2_i,
    input  ex_memRead_i, ex_wReg_i, ex_wRegAddr_i, mem_req_i,
    output stall_o, bubble_o, mem_done_o, busy_o
  );

endinterface

// File: rtl/pipe_ctrl_stall_merge.sv
// Priority merge of per-stage requests: the deepest requester holds itself and
// everything upstream, and the register just downstream of it takes a bubble.
module pipe_ctrl_stall_merge
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned N_STAGES = DEF_N_STAGES
) (
  input  logic [N_STAGES-1:0] req_i,
  output logic [N_STAGES-1:0] stall_o,
  output logic [N_STAGES-1:0] bubble_o
);

  // Stage k holds whenever any stage at or below it in the pipe requests.
  for (genvar k = 0; k < N_STAGES; k++) begin : g_stall
    assign stall_o[k] = |req_i[N_STAGES-1:k];
  end

  assign bubble_o[0] = 1'b0;
  for (genvar k = 1; k < N_STAGES; k++) begin : g_bubble
    assign bubble_o[k] = stall_o[k-1] & ~stall_o[k];
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/bubble/flush controller: merges external stalls, load-use
// hazards and the shared-SRAM wait-state FSM into per-stage hold/bubble vectors.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned N_STAGES   = DEF_N_STAGES,
  parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int unsigned ID_STAGE   = STAGE_IFID,
  parameter int unsigned MEM_STAGE  = STAGE_EXMEM,
  parameter int unsigned MEM_WAIT   = DEF_MEM_WAIT
) (
  input  logic      clk,
  input  logic      rst,
  pipe_ctrl_if.slave bus
);

  localparam logic [MEM_CNT_W-1:0] WAIT_LAST =
    MEM_CNT_W'((MEM_WAIT > 0) ? (MEM_WAIT - 1) : 0);

  mem_state_e            state_q, state_d;
  logic [MEM_CNT_W-1:0]  cnt_q, cnt_d;
  logic                  wait_req;
  logic                  done_req;
  logic                  load_use;
  logic [REG_ADDR_W-1:0] ex_dst;
  logic [N_STAGES-1:0]   req;
  logic [N_STAGES-1:0]   stall_m;
  logic [N_STAGES-1:0]   bubble_m;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MS_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // SRAM wait-state sequencing; flush abandons any in-flight access.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wait_req = 1'b0;
    done_req = 1'b0;
    case (state_q)
      MS_IDLE: begin
        if (bus.mem_req_i) begin
          if (MEM_WAIT > 0) begin
            state_d = MS_WAIT;
            cnt_d   = '0;
          end else begin
            state_d = MS_DONE;
          end
        end
      end
      MS_WAIT: begin
        wait_req = 1'b1;
        cnt_d    = cnt_q + MEM_CNT_W'(1);
        if (cnt_q == WAIT_LAST) begin
          state_d = MS_DONE;
        end
      end
      MS_DONE: begin
        done_req = 1'b1;
        state_d  = MS_FETCH;
      end
      MS_FETCH: begin
        state_d = MS_IDLE;
      end
      default: begin
        state_d = MS_IDLE;
      end
    endcase
    if (bus.flush_i) begin
      state_d = MS_IDLE;
      cnt_d   = '0;
    end
  end

  assign ex_dst = bus.ex_wRegAddr_i;

  always_comb begin
    load_use = bus.ex_memRead_i & bus.ex_wReg_i &
               ((bus.id_rEnable1_i & (bus.id_rAddr1_i == ex_dst)) |
                (bus.id_rEnable2_i & (bus.id_rAddr2_i == ex_dst)));
  end

  // During DONE the bus still serves data, so instruction fetch waits at the PC.
  always_comb begin
    req = bus.stallreq_i;
    if (load_use) req[ID_STAGE]  = 1'b1;
    if (wait_req) req[MEM_STAGE] = 1'b1;
    if (done_req) req[STAGE_PC]  = 1'b1;
  end

  pipe_ctrl_stall_merge #(
    .N_STAGES (N_STAGES)
  ) u_merge (
    .req_i    (req),
    .stall_o  (stall_m),
    .bubble_o (bubble_m)
  );

  // Reset and flush both drain the pipe with NOPs and release every hold.
  always_comb begin
    bus.stall_o    = stall_m;
    bus.bubble_o   = bubble_m;
    bus.mem_done_o = done_req;
    bus.busy_o     = (state_q != MS_IDLE);
    if (bus.flush_i) begin
      bus.stall_o    = '0;
      bus.bubble_o   = '1;
      bus.mem_done_o = 1'b0;
    end
    if (rst) begin
      bus.stall_o    = '0;
      bus.bubble_o   = '1;
      bus.mem_done_o = 1'b0;
      bus.busy_o     = 1'b0;
    end
  end

endmodule
